// File: rtl/dsp_iq_mult_sched_pkg.sv
// Shared definitions for the IQ multiplier scheduler.
// Holds the channel-ID and occupancy-count width helpers and the tag type
// for the default configuration (4 channels, 8 outstanding operations).
// No ports.
package dsp_iq_mult_sched_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_MAX_OUTSTANDING = 8;

  localparam int ID_WIDTH  = $clog2(DEF_CHANNELS);
  localparam int CNT_WIDTH = $clog2(DEF_MAX_OUTSTANDING) + 1;

  typedef logic [ID_WIDTH-1:0] tag_t;

  // Width of a channel ID; at least one bit even for degenerate sizes.
  function automatic int id_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Occupancy counter width: one extra bit so "full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsp_iq_mult_sched_tag_fifo.sv
// In-order channel-ID FIFO for the IQ multiplier scheduler.
// Records which channel each issued operation belongs to so the returning
// product can be steered back to it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (control only)
//   push        write push_id at the tail
//   push_id     channel ID to record
//   pop         drop the head entry
//   head        channel ID at the head (valid while count != 0)
//   count       number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module dsp_iq_mult_sched_tag_fifo
  import dsp_iq_mult_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ID_W  = 2,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dsp_iq_mult_sched.sv
// Round-robin scheduler sharing one IQ multiplier among CHANNELS requesters.
// Operand pairs are arbitrated, captured in a one-entry issue register that
// drives the multiplier, and tagged with their channel in an in-order FIFO.
// Products come back in issue order and are steered to the channel at the
// FIFO head; a blocked head stalls the whole return path.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_{a,b}_{i,q}_tdata           per-channel operands, channel n at [n*WIDTH +: WIDTH]
//   req_tvalid / req_tready         per-channel operand-pair handshake
//   mult_{a,b}_{i,q}_tdata          operands to the shared multiplier
//   mult_tvalid / mult_tready       multiplier operand handshake
//   res_{i,q}_tdata                 products from the multiplier (issue order)
//   res_tvalid / res_tready         product handshake
//   out_{i,q}_tdata                 product bus shared by all channels
//   out_tvalid / out_tready         one-hot destination valid, per-channel ready
//   tag_err                         sticky: product arrived with no tag pending
// Optional build macro DSP_IQ_MULT_SCHED_STATS_EN adds grant_count, one
// 32-bit wrapping accept counter per channel (channel n at [n*32 +: 32]).
module dsp_iq_mult_sched
  import dsp_iq_mult_sched_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int CHANNELS        = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*WIDTH-1:0]    req_a_i_tdata,
  input  logic [CHANNELS*WIDTH-1:0]    req_a_q_tdata,
  input  logic [CHANNELS*WIDTH-1:0]    req_b_i_tdata,
  input  logic [CHANNELS*WIDTH-1:0]    req_b_q_tdata,
  input  logic [CHANNELS-1:0]          req_tvalid,
  output logic [CHANNELS-1:0]          req_tready,
  output logic signed [WIDTH-1:0]      mult_a_i_tdata,
  output logic signed [WIDTH-1:0]      mult_a_q_tdata,
  output logic signed [WIDTH-1:0]      mult_b_i_tdata,
  output logic signed [WIDTH-1:0]      mult_b_q_tdata,
  output logic                         mult_tvalid,
  input  logic                         mult_tready,
  input  logic signed [2*WIDTH-1:0]    res_i_tdata,
  input  logic signed [2*WIDTH-1:0]    res_q_tdata,
  input  logic                         res_tvalid,
  output logic                         res_tready,
  output logic signed [2*WIDTH-1:0]    out_i_tdata,
  output logic signed [2*WIDTH-1:0]    out_q_tdata,
  output logic [CHANNELS-1:0]          out_tvalid,
  input  logic [CHANNELS-1:0]          out_tready,
  output logic                         tag_err
`ifdef DSP_IQ_MULT_SCHED_STATS_EN
  ,
  output logic [CHANNELS*32-1:0]       grant_count
`endif
);

  localparam int ID_W  = id_width(CHANNELS);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(CHANNELS - 1);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic             grant_vld;
  logic             can_load;
  logic             accept;

  logic signed [WIDTH-1:0] sel_a_i, sel_a_q, sel_b_i, sel_b_q;
  logic signed [WIDTH-1:0] a_i_p0, a_q_p0, b_i_p0, b_q_p0;
  logic                    vld_p0;

  logic [ID_W-1:0]  head;
  logic [CNT_W-1:0] count;
  logic             cnt_nz;
  logic             pop;

  // ---------------------------------------------------------------------
  // Arbitration: first valid channel at or after the round-robin pointer.
  // ---------------------------------------------------------------------
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(rr_ptr) + k) % CHANNELS;
      if (!grant_vld && req_tvalid[idx]) begin
        grant     = ID_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Occupancy is the registered count, so a pop in this cycle does not
  // free a slot until the next one.
  assign can_load = (!vld_p0 || mult_tready) && (count < FULL_CNT);
  assign accept   = grant_vld && can_load;

  always_comb begin
    req_tready = '0;
    if (accept) begin
      req_tready[grant] = 1'b1;
    end
  end

  always_comb begin
    sel_a_i = '0;
    sel_a_q = '0;
    sel_b_i = '0;
    sel_b_q = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (grant == ID_W'(n)) begin
        sel_a_i = req_a_i_tdata[n*WIDTH +: WIDTH];
        sel_a_q = req_a_q_tdata[n*WIDTH +: WIDTH];
        sel_b_i = req_b_i_tdata[n*WIDTH +: WIDTH];
        sel_b_q = req_b_q_tdata[n*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == LAST_ID) ? '0 : grant + ID_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Stage p0: issue register feeding the shared multiplier.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      a_i_p0 <= '0;
      a_q_p0 <= '0;
      b_i_p0 <= '0;
      b_q_p0 <= '0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      a_i_p0 <= sel_a_i;
      a_q_p0 <= sel_a_q;
      b_i_p0 <= sel_b_i;
      b_q_p0 <= sel_b_q;
    end else if (mult_tready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign mult_tvalid    = vld_p0;
  assign mult_a_i_tdata = a_i_p0;
  assign mult_a_q_tdata = a_q_p0;
  assign mult_b_i_tdata = b_i_p0;
  assign mult_b_q_tdata = b_q_p0;

  dsp_iq_mult_sched_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (grant),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

  // ---------------------------------------------------------------------
  // Return path: combinational steer of the product to the head channel.
  // ---------------------------------------------------------------------
  assign cnt_nz      = (count != '0);
  assign res_tready  = cnt_nz && out_tready[head];
  assign pop         = res_tvalid && res_tready;
  assign out_i_tdata = res_i_tdata;
  assign out_q_tdata = res_q_tdata;

  always_comb begin
    out_tvalid = '0;
    if (res_tvalid && cnt_nz) begin
      out_tvalid[head] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (res_tvalid && !cnt_nz) begin
      tag_err <= 1'b1;
    end
  end

`ifdef DSP_IQ_MULT_SCHED_STATS_EN
  logic [31:0] grant_cnt [CHANNELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        grant_cnt[n] <= '0;
      end
    end else if (accept) begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (grant == ID_W'(n)) begin
          grant_cnt[n] <= grant_cnt[n] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_stats
    assign grant_count[g*32 +: 32] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_dsp_iq_mult_sched.sv
// Directed bench for dsp_iq_mult_sched: 4 channels, 16-bit operands,
// 8 outstanding. A latency-4 multiplier model computes the per-component
// products (a_i*b_i, a_q*b_q) and returns them in issue order.
module tb_dsp_iq_mult_sched;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int MO = 8;

  logic                    clk;
  logic                    rst_n;
  logic [CH*W-1:0]         req_a_i_tdata, req_a_q_tdata, req_b_i_tdata, req_b_q_tdata;
  logic [CH-1:0]           req_tvalid;
  logic [CH-1:0]           req_tready;
  logic signed [W-1:0]     mult_a_i_tdata, mult_a_q_tdata, mult_b_i_tdata, mult_b_q_tdata;
  logic                    mult_tvalid;
  logic                    mult_tready;
  logic signed [2*W-1:0]   res_i_tdata, res_q_tdata;
  logic                    res_tvalid;
  logic                    res_tready;
  logic signed [2*W-1:0]   out_i_tdata, out_q_tdata;
  logic [CH-1:0]           out_tvalid;
  logic [CH-1:0]           out_tready;
  logic                    tag_err;

  dsp_iq_mult_sched #(
    .WIDTH           (W),
    .CHANNELS        (CH),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_a_i_tdata  (req_a_i_tdata),
    .req_a_q_tdata  (req_a_q_tdata),
    .req_b_i_tdata  (req_b_i_tdata),
    .req_b_q_tdata  (req_b_q_tdata),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .mult_a_i_tdata (mult_a_i_tdata),
    .mult_a_q_tdata (mult_a_q_tdata),
    .mult_b_i_tdata (mult_b_i_tdata),
    .mult_b_q_tdata (mult_b_q_tdata),
    .mult_tvalid    (mult_tvalid),
    .mult_tready    (mult_tready),
    .res_i_tdata    (res_i_tdata),
    .res_q_tdata    (res_q_tdata),
    .res_tvalid     (res_tvalid),
    .res_tready     (res_tready),
    .out_i_tdata    (out_i_tdata),
    .out_q_tdata    (out_q_tdata),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .tag_err        (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    logic signed [31:0] pi;
    logic signed [31:0] pq;
  } prod_t;

  typedef struct {
    int ch;
    int ei;
    int eq;
    int ov;
  } ent_t;

  prod_t prod_q[$];
  ent_t  iss_q[$];
  ent_t  deliv_q[$];
  int    seq [CH];
  int    cyc;
  int    n_acc;
  int    hot_err;
  bit    hold;
  int    budget;
  int    n_chk;
  int    n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Channel n presents A = (n+1) + j2, B = 5 + j(7+seq[n]).
  task automatic drive_req();
    for (int n = 0; n < CH; n++) begin
      req_a_i_tdata[n*W +: W] = 16'(n + 1);
      req_a_q_tdata[n*W +: W] = 16'd2;
      req_b_i_tdata[n*W +: W] = 16'd5;
      req_b_q_tdata[n*W +: W] = 16'(7 + seq[n]);
    end
  endtask

  task automatic drive_res();
    if (prod_q.size() > 0 && prod_q[0].due <= cyc && (!hold || budget > 0)) begin
      res_tvalid  = 1'b1;
      res_i_tdata = prod_q[0].pi;
      res_q_tdata = prod_q[0].pq;
    end else begin
      res_tvalid  = 1'b0;
      res_i_tdata = '0;
      res_q_tdata = '0;
    end
  endtask

  // Sample handshakes before the edge, advance one clock, update the models.
  task automatic tick();
    prod_t p;
    #1;
    if ($countones(req_tready) > 1) hot_err++;
    for (int n = 0; n < CH; n++) begin
      if (req_tvalid[n] && req_tready[n]) begin
        iss_q.push_back('{n, (n + 1) * 5, 2 * (7 + seq[n]), 0});
        seq[n]++;
        n_acc++;
      end
    end
    if (mult_tvalid && mult_tready) begin
      p.due = cyc + 4;
      p.pi  = 32'(mult_a_i_tdata) * 32'(mult_b_i_tdata);
      p.pq  = 32'(mult_a_q_tdata) * 32'(mult_b_q_tdata);
      prod_q.push_back(p);
    end
    for (int n = 0; n < CH; n++) begin
      if (out_tvalid[n] && out_tready[n]) begin
        deliv_q.push_back('{n, int'(out_i_tdata), int'(out_q_tdata), int'(out_tvalid)});
      end
    end
    if (res_tvalid && res_tready && prod_q.size() > 0) begin
      void'(prod_q.pop_front());
      if (budget > 0) budget--;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_req();
    drive_res();
  endtask

  function automatic int log_mismatch();
    int m;
    int lim;
    m   = (deliv_q.size() != iss_q.size()) ? 1 : 0;
    lim = (deliv_q.size() < iss_q.size()) ? deliv_q.size() : iss_q.size();
    for (int i = 0; i < lim; i++) begin
      if (deliv_q[i].ch != iss_q[i].ch || deliv_q[i].ei != iss_q[i].ei ||
          deliv_q[i].eq != iss_q[i].eq) m++;
    end
    return m;
  endfunction

  initial begin
    int a0;
    int d0;
    int k2;
    n_chk = 0; n_fail = 0; cyc = 0; n_acc = 0; hot_err = 0;
    hold = 1'b0; budget = 0;
    for (int n = 0; n < CH; n++) seq[n] = 0;
    rst_n = 1'b0;
    req_tvalid = '0;
    mult_tready = 1'b1;
    out_tready = '1;
    res_tvalid = 1'b0; res_i_tdata = '0; res_q_tdata = '0;
    drive_req();

    // Reset state
    #12;
    chk("rst_mult_tvalid", 32'(mult_tvalid), 0);
    chk("rst_mult_a_i",    32'(mult_a_i_tdata), 0);
    chk("rst_mult_b_q",    32'(mult_b_q_tdata), 0);
    chk("rst_req_tready",  32'(req_tready), 0);
    chk("rst_res_tready",  32'(res_tready), 0);
    chk("rst_out_tvalid",  32'(out_tvalid), 0);
    chk("rst_tag_err",     32'(tag_err), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Product with empty tag FIFO
    res_tvalid = 1'b1; res_i_tdata = 32'd99; res_q_tdata = 32'd98;
    #1;
    chk("err_res_tready", 32'(res_tready), 0);
    chk("err_out_tvalid", 32'(out_tvalid), 0);
    tick();
    chk("err_set", 32'(tag_err), 1);
    repeat (3) tick();
    chk("err_sticky", 32'(tag_err), 1);
    @(negedge clk) rst_n = 1'b0;
    #2;
    chk("err_cleared_by_rst", 32'(tag_err), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with all channels valid
    req_tvalid = 4'hF;
    repeat (12) tick();
    req_tvalid = '0;
    repeat (12) tick();
    chk("rr_accepts", 32'(n_acc), 12);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_order%0d", i), 32'(iss_q[i].ch), 32'(i % 4));
    chk("rr_delivered", 32'(deliv_q.size()), 12);
    k2 = 0;
    for (int i = deliv_q.size() - 1; i >= 0; i--) if (deliv_q[i].ch == 2) k2 = i;
    chk("ch2_out_i",    32'(deliv_q[k2].ei), 15);
    chk("ch2_out_q",    32'(deliv_q[k2].eq), 14);
    chk("ch2_onehot",   32'(deliv_q[k2].ov), 32'h4);
    chk("rr_inorder",   32'(log_mismatch()), 0);

    // Pointer wrap: only ch1 valid
    req_tvalid = 4'b0010;
    #1 chk("wrap_first", 32'(req_tready), 32'h2);
    tick();
    chk("wrap_grant", 32'(req_tready), 32'h2);
    tick();
    req_tvalid = '0;
    repeat (3) tick();
    req_tvalid = 4'b1110;
    #1 chk("wrap_ptr_is_2", 32'(req_tready), 32'h4);
    req_tvalid = 4'b1010;
    #1 chk("wrap_ptr_skip", 32'(req_tready), 32'h8);
    req_tvalid = '0;
    repeat (10) tick();

    // Multiplier backpressure holds the issue register
    mult_tready = 1'b0;
    req_tvalid  = 4'b0001;
    a0 = n_acc;
    tick();
    chk("bp_ready_low", 32'(req_tready), 0);
    chk("bp_mult_vld",  32'(mult_tvalid), 1);
    chk("bp_mult_a_i",  32'(mult_a_i_tdata), 1);
    repeat (3) tick();
    chk("bp_vld_held",  32'(mult_tvalid), 1);
    chk("bp_accepts",   32'(n_acc - a0), 1);
    req_tvalid  = '0;
    mult_tready = 1'b1;
    repeat (10) tick();

    // Tag FIFO full: results withheld
    hold = 1'b1; budget = 0;
    req_tvalid = 4'hF;
    a0 = n_acc;
    repeat (20) tick();
    chk("full_accepts", 32'(n_acc - a0), 8);
    chk("full_ready",   32'(req_tready), 0);
    budget = 1;
    drive_res();
    a0 = n_acc;
    repeat (3) tick();
    chk("full_one_more", 32'(n_acc - a0), 1);
    chk("full_ready2",   32'(req_tready), 0);
    req_tvalid = '0;
    hold = 1'b0;
    repeat (20) tick();
    chk("full_inorder", 32'(log_mismatch()), 0);

    // Head-of-line blocking
    req_tvalid = 4'b1000;
    tick();
    req_tvalid = 4'b0001;
    tick();
    req_tvalid = '0;
    out_tready = 4'b0111;
    d0 = deliv_q.size();
    repeat (10) tick();
    chk("hol_res_tready", 32'(res_tready), 0);
    chk("hol_out_tvalid", 32'(out_tvalid), 32'h8);
    chk("hol_data_i",     32'(out_i_tdata), 20);
    chk("hol_no_pop",     32'(deliv_q.size() - d0), 0);
    out_tready = 4'hF;
    repeat (10) tick();
    chk("hol_delivered",  32'(deliv_q.size() - d0), 2);
    chk("hol_first_ch",   32'(deliv_q[d0].ch), 3);
    chk("hol_second_ch",  32'(deliv_q[d0+1].ch), 0);
    chk("hol_inorder",    32'(log_mismatch()), 0);

    // Asynchronous reset with 3 outstanding
    hold = 1'b1; budget = 0;
    req_tvalid = 4'b0010;
    repeat (3) tick();
    req_tvalid = '0;
    res_tvalid = 1'b1;
    #1;
    chk("pre_rst_res_tready", 32'(res_tready), 1);
    chk("pre_rst_out_tvalid", 32'(out_tvalid), 32'h2);
    chk("pre_rst_mult_vld",   32'(mult_tvalid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_mult_vld",   32'(mult_tvalid), 0);
    chk("arst_mult_a_i",   32'(mult_a_i_tdata), 0);
    chk("arst_res_tready", 32'(res_tready), 0);
    chk("arst_out_tvalid", 32'(out_tvalid), 0);
    chk("arst_req_tready", 32'(req_tready), 0);
    prod_q.delete();
    hold = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_count0", 32'(res_tready), 0);
    @(posedge clk); #1;
    chk("post_rst_tag_err", 32'(tag_err), 1);
    res_tvalid = 1'b0;

    chk("ready_onehot", 32'(hot_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
